ifu_fetch: RTL

- Instruction fetch stage, directly upstream of the load/store unit.
- Owns the PC and issues one AXI-lite-style read per instruction to the instruction SRAM.
- Presents the fetched word with a one-cycle `ifu_rdata_valid` pulse, then holds until the LSU reports `lsu_finish`.
- On `lsu_finish`, loads the next PC (`dnpc`) and fetches again, so exactly one instruction is in flight.

---
 rtl/ifu_fetch_if.sv | 33 +++
 rtl/ifu_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Instruction-SRAM read channel (AR + R) between the fetch unit and the SRAM.
// VALID/READY: a beat transfers on a posedge where both are 1; the source holds payload stable while VALID waits.
interface ifu_fetch_if #(
   parameter int XLEN = 32
);
   logic            arvalid;
   logic [XLEN-1:0] araddr;
   logic            arready;
   logic            rvalid;
   logic            rready;
   logic [XLEN-1:0] rdata;
   logic [1:0]      rresp;

   modport master (
      output arvalid,
      output araddr,
      input  arready,
      input  rvalid,
      output rready,
      input  rdata,
      input  rresp
   );

   modport slave (
      input  arvalid,
      input  araddr,
      output arready,
      output rvalid,
      input  rready,
      output rdata,
      output rresp
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one SRAM read per instruction, holds until the LSU retires it.
// Optional macro IFU_FAULT_CHECK_EN adds misalignment/bus-error trapping (inst_fault output, S_FAULT state).
module ifu_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] dnpc,
   input  logic            lsu_finish,
   ifu_fetch_if.master     bus,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] inst,
   output logic            ifu_rdata_valid,
`ifdef IFU_FAULT_CHECK_EN
   output logic            inst_fault,
`endif
   output logic [4:0]      state_dbg
);

`ifdef IFU_FAULT_CHECK_EN
   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_AR    = 5'b00010,
      S_R     = 5'b00100,
      S_EXEC  = 5'b01000,
      S_FAULT = 5'b10000
   } state_e;
`else
   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_AR   = 4'b0010,
      S_R    = 4'b0100,
      S_EXEC = 4'b1000
   } state_e;
`endif

   localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            rdv_q, rdv_d;
   logic            arvalid_c;
   logic            rready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         rdv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         rdv_q   <= rdv_d;
      end
   end

   // Bus strobes are pure decodes of registered state/pc, so they never glitch.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      rdv_d     = 1'b0;
      arvalid_c = 1'b0;
      rready_c  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_AR;
         end
         S_AR: begin
`ifdef IFU_FAULT_CHECK_EN
            if (pc_q[1:0] != 2'b00) begin
               state_d = S_FAULT;
            end else begin
               arvalid_c = 1'b1;
               if (bus.arready) state_d = S_R;
            end
`else
            arvalid_c = 1'b1;
            if (bus.arready) state_d = S_R;
`endif
         end
         S_R: begin
            rready_c = 1'b1;
            if (bus.rvalid) begin
`ifdef IFU_FAULT_CHECK_EN
               if (bus.rresp != 2'b00) begin
                  inst_d  = NOP_INST;
                  state_d = S_FAULT;
               end else begin
                  inst_d  = bus.rdata;
                  rdv_d   = 1'b1;
                  state_d = S_EXEC;
               end
`else
               inst_d  = bus.rdata;
               rdv_d   = 1'b1;
               state_d = S_EXEC;
`endif
            end
         end
         S_EXEC: begin
            // dnpc is taken verbatim; the fetch unit never computes a PC itself.
            if (lsu_finish) begin
               pc_d    = dnpc;
               state_d = S_AR;
            end
         end
`ifdef IFU_FAULT_CHECK_EN
         S_FAULT: begin
            state_d = S_FAULT;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.arvalid     = arvalid_c;
   assign bus.araddr      = pc_q;
   assign bus.rready      = rready_c;
   assign pc              = pc_q;
   assign inst            = inst_q;
   assign ifu_rdata_valid = rdv_q;
   assign state_dbg       = 5'(state_q);

`ifdef IFU_FAULT_CHECK_EN
   assign inst_fault = (state_q == S_FAULT);
`else
   logic unused_rresp;
   assign unused_rresp = ^bus.rresp;
`endif

   a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state_q));
   a_ar_stable: assert property (@(posedge clk) disable iff (rst)
      (bus.arvalid && !bus.arready) |=> (bus.arvalid && $stable(bus.araddr)));
   a_rdv_pulse: assert property (@(posedge clk) disable iff (rst)
      ifu_rdata_valid |=> !ifu_rdata_valid);
   a_one_channel: assert property (@(posedge clk) disable iff (rst)
      !(bus.arvalid && bus.rready));

endmodule
